// File: rtl/status_flag_register.sv
// status_flag_register: derives NZCV from the EXE-stage ALU operation and
// holds both the architectural status register and a one-entry shadow copy
// that is used for exception entry and return.
module status_flag_register #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] RESET_SR = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  input  logic             s_bit,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             shifter_carry,
  input  logic             flush,
  input  logic             freeze,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       sr,
  output logic [3:0]       sr_fwd,
  output logic [3:0]       shadow_sr,
  output logic             sr_updated
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic             is_arith;
  logic             cmd_known;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;
  logic             flag_we;
  logic [3:0]       pre_restore_sr;
  logic [3:0]       shadow_next;
  logic             updated_next;

  // ALU datapath and flag derivation; subtraction is an add of ~op_b so one
  // adder serves all four arithmetic commands and the overflow rule is shared.
  always_comb begin
    addend    = op_b;
    carry_in  = 1'b0;
    is_arith  = 1'b0;
    cmd_known = 1'b1;
    logic_res = '0;
    case (exe_cmd)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        carry_in = sr[1];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        addend   = ~op_b;
        carry_in = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        addend   = ~op_b;
        carry_in = sr[1];
      end
      CMD_MOV: logic_res = op_b;
      CMD_MVN: logic_res = ~op_b;
      CMD_AND: logic_res = op_a & op_b;
      CMD_ORR: logic_res = op_a | op_b;
      CMD_EOR: logic_res = op_a ^ op_b;
      default: cmd_known = 1'b0;
    endcase

    sum = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};

    if (!cmd_known) begin
      alu_result = '0;
    end else if (is_arith) begin
      alu_result = sum[WIDTH-1:0];
    end else begin
      alu_result = logic_res;
    end

    alu_flags[3] = alu_result[WIDTH-1];
    alu_flags[2] = (alu_result == '0);
    if (is_arith) begin
      alu_flags[1] = sum[WIDTH];
      alu_flags[0] = (op_a[WIDTH-1] == addend[WIDTH-1]) &&
                     (alu_result[WIDTH-1] != op_a[WIDTH-1]);
    end else begin
      alu_flags[1] = shifter_carry;
      alu_flags[0] = sr[0];
    end

    if (!cmd_known) begin
      alu_flags = sr;
    end
  end

  // Next-state selection: freeze beats restore beats a flag write; the
  // shadow always captures the value that excludes the restore so that
  // save+restore together swaps the two registers.
  always_comb begin
    flag_we        = exe_valid & s_bit & ~flush & ~freeze;
    pre_restore_sr = flag_we ? alu_flags : sr;
    sr_fwd         = sr;
    updated_next   = 1'b0;
    shadow_next    = shadow_sr;
    if (!freeze) begin
      if (restore) begin
        sr_fwd       = shadow_sr;
        updated_next = 1'b1;
      end else if (flag_we) begin
        sr_fwd       = alu_flags;
        updated_next = 1'b1;
      end
      if (save) begin
        shadow_next = pre_restore_sr;
      end
    end
  end

  // Architectural status, shadow copy and update pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= RESET_SR;
      shadow_sr  <= RESET_SR;
      sr_updated <= 1'b0;
    end else begin
      sr         <= sr_fwd;
      shadow_sr  <= shadow_next;
      sr_updated <= updated_next;
    end
  end

endmodule

// File: tb/tb_status_flag_register.sv
// tb_status_flag_register: directed literal checks plus randomized stimulus
// compared every cycle against a signed/unsigned arithmetic reference model.
module tb_status_flag_register;

  localparam int     W    = 32;
  localparam longint MASK = 64'hFFFF_FFFF;
  localparam longint MOD  = 64'h1_0000_0000;
  localparam longint HALF = 64'h8000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           exe_valid = 1'b0;
  logic           s_bit = 1'b0;
  logic [3:0]     exe_cmd = 4'd0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           shifter_carry = 1'b0;
  logic           flush = 1'b0;
  logic           freeze = 1'b0;
  logic           save = 1'b0;
  logic           restore = 1'b0;
  logic [W-1:0]   alu_result;
  logic [3:0]     sr;
  logic [3:0]     sr_fwd;
  logic [3:0]     shadow_sr;
  logic           sr_updated;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_sr  = 4'b0000;
  logic [3:0] m_sh  = 4'b0000;
  logic       m_upd = 1'b0;

  status_flag_register #(.WIDTH(W), .RESET_SR(4'b0000)) dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .s_bit(s_bit),
    .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
    .shifter_carry(shifter_carry), .flush(flush), .freeze(freeze),
    .save(save), .restore(restore), .alu_result(alu_result), .sr(sr),
    .sr_fwd(sr_fwd), .shadow_sr(shadow_sr), .sr_updated(sr_updated)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s,
                               input logic [3:0] cmd, input logic [31:0] a,
                               input logic [31:0] b, input logic shc,
                               input logic fl, input logic fz,
                               input logic sv, input logic rs);
    exe_valid = v; s_bit = s; exe_cmd = cmd; op_a = a; op_b = b;
    shifter_carry = shc; flush = fl; freeze = fz; save = sv; restore = rs;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nextCycle();
    applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0);
  endtask

  // Reference ALU: arithmetic done on wide integers, carry as an unsigned
  // comparison and overflow as an out-of-range signed ideal result.
  function automatic void refAlu(input logic [3:0] cmd, input longint a,
                                 input longint b, input logic shc,
                                 input logic [3:0] cur, output longint res,
                                 output logic [3:0] fl);
    longint sa, sb, ideal;
    logic   c, v, known, arith;
    c = cur[1]; v = cur[0]; known = 1; arith = 1; ideal = 0; res = 0;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    case (cmd)
      4'b0010: begin res = (a + b) & MASK; c = (a + b) >= MOD; ideal = sa + sb; end
      4'b0011: begin
        res = (a + b + longint'(cur[1])) & MASK;
        c = (a + b + longint'(cur[1])) >= MOD;
        ideal = sa + sb + longint'(cur[1]);
      end
      4'b0100: begin res = (a - b) & MASK; c = a >= b; ideal = sa - sb; end
      4'b0101: begin
        res = (a - b - 1 + longint'(cur[1])) & MASK;
        c = (a + longint'(cur[1])) > b;
        ideal = sa - sb - 1 + longint'(cur[1]);
      end
      4'b0001: begin res = b; arith = 0; end
      4'b1001: begin res = ~b & MASK; arith = 0; end
      4'b0110: begin res = a & b; arith = 0; end
      4'b0111: begin res = a | b; arith = 0; end
      4'b1000: begin res = a ^ b; arith = 0; end
      default: known = 0;
    endcase
    if (arith) v = (ideal > HALF - 1) || (ideal < -HALF);
    else c = shc;
    if (!known) begin
      res = 0;
      fl  = cur;
    end else begin
      fl = {res >= HALF, res == 0, c, v};
    end
  endfunction

  // Compare process: every cycle the model's view of the outputs is checked
  // at the falling edge and its state advances at the rising edge.
  initial begin
    longint     e_res;
    logic [3:0] e_fl, e_fwd, n_sh;
    logic       we, n_upd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_sr = 4'b0000; m_sh = 4'b0000; m_upd = 1'b0;
      end
      refAlu(exe_cmd, longint'(op_a), longint'(op_b), shifter_carry, m_sr,
             e_res, e_fl);
      we    = exe_valid & s_bit & ~flush & ~freeze;
      e_fwd = m_sr;
      n_upd = 1'b0;
      n_sh  = m_sh;
      if (!freeze && restore) begin
        e_fwd = m_sh; n_upd = 1'b1;
      end else if (we) begin
        e_fwd = e_fl; n_upd = 1'b1;
      end
      if (!freeze && save) n_sh = we ? e_fl : m_sr;
      checkOutput("alu_result", alu_result, e_res[31:0]);
      checkOutput("sr_fwd", {28'd0, sr_fwd}, {28'd0, e_fwd});
      checkOutput("sr", {28'd0, sr}, {28'd0, m_sr});
      checkOutput("shadow_sr", {28'd0, shadow_sr}, {28'd0, m_sh});
      checkOutput("sr_updated", {31'd0, sr_updated}, {31'd0, m_upd});
      @(posedge clk);
      if (rst) begin
        m_sr = e_fwd; m_sh = n_sh; m_upd = n_upd;
      end
    end
  end

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Main stimulus: directed scenarios with literal expectations, then a
  // randomized run with occasional asynchronous resets mid-operation.
  initial begin
    $display("[TB] start");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1, 1, 4'($urandom_range(0, 15)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 0, 0, 1, 1);
    end
    #1;
    checkOutput("reset_sr", {28'd0, sr}, 32'h0);
    checkOutput("reset_shadow", {28'd0, shadow_sr}, 32'h0);
    checkOutput("reset_upd", {31'd0, sr_updated}, 32'h0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    idle();
    checkOutput("post_reset_sr", {28'd0, sr}, 32'h0);
    checkOutput("post_reset_shadow", {28'd0, shadow_sr}, 32'h0);

    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ovf_result", alu_result, 32'h8000_0000);
    checkOutput("ovf_fwd", {28'd0, sr_fwd}, 32'h9);
    idle();
    checkOutput("ovf_sr", {28'd0, sr}, 32'h9);
    checkOutput("ovf_upd", {31'd0, sr_updated}, 32'h1);
    idle();
    checkOutput("ovf_upd_drop", {31'd0, sr_updated}, 32'h0);

    nextCycle();
    applyStimulus(1, 1, 4'b0100, 32'd5, 32'd5, 0, 0, 0, 0, 0);
    idle();
    checkOutput("sub_zero_sr", {28'd0, sr}, 32'h6);
    nextCycle();
    applyStimulus(1, 1, 4'b0101, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("sbc_c1_result", alu_result, 32'h0);
    idle();
    checkOutput("sbc_c1_sr", {28'd0, sr}, 32'h6);
    nextCycle();
    applyStimulus(1, 1, 4'b0100, 32'd0, 32'd1, 0, 0, 0, 0, 0);
    idle();
    checkOutput("sub_borrow_sr", {28'd0, sr}, 32'h8);
    nextCycle();
    applyStimulus(1, 1, 4'b0101, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("sbc_c0_result", alu_result, 32'hFFFF_FFFF);
    idle();
    checkOutput("sbc_c0_sr", {28'd0, sr}, 32'h8);

    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 4'b0110, 32'hF0, 32'h0F, 1, 0, 0, 0, 0);
    #1;
    checkOutput("and_result", alu_result, 32'h0);
    idle();
    checkOutput("and_sr", {28'd0, sr}, 32'h7);

    nextCycle();
    applyStimulus(1, 0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    idle();
    checkOutput("nos_sr", {28'd0, sr}, 32'h7);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 1, 0, 0, 0);
    idle();
    checkOutput("flush_sr", {28'd0, sr}, 32'h7);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 0, 0);
    idle();
    checkOutput("freeze_sr", {28'd0, sr}, 32'h7);
    checkOutput("freeze_upd", {31'd0, sr_updated}, 32'h0);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    idle();
    checkOutput("clear_sr", {28'd0, sr}, 32'h6);

    nextCycle();
    applyStimulus(1, 1, 4'b0100, 32'd0, 32'd1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0);
    idle();
    checkOutput("save_shadow", {28'd0, shadow_sr}, 32'h8);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 1);
    #1;
    checkOutput("restore_fwd", {28'd0, sr_fwd}, 32'h8);
    idle();
    checkOutput("restore_sr", {28'd0, sr}, 32'h8);
    checkOutput("restore_upd", {31'd0, sr_updated}, 32'h1);
    nextCycle();
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 1, 1);
    idle();
    checkOutput("swap_sr", {28'd0, sr}, 32'h8);
    checkOutput("swap_shadow", {28'd0, shadow_sr}, 32'h6);

    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      rst = 1'b1;
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                    4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b0;
      end
    end
    nextCycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
